// File: rtl/aes_decipher_ctrl_pkg.sv
// aes_decipher_ctrl_pkg: shared AES encodings for the decipher controller and datapath.
package aes_decipher_ctrl_pkg;
    localparam logic [2:0] UPD_NO    = 3'd0;
    localparam logic [2:0] UPD_INIT  = 3'd1;
    localparam logic [2:0] UPD_SBOX  = 3'd2;
    localparam logic [2:0] UPD_MAIN  = 3'd3;
    localparam logic [2:0] UPD_FINAL = 3'd4;
    localparam logic [3:0] AES_128_NUM_ROUNDS = 4'ha;
    localparam logic [3:0] AES_256_NUM_ROUNDS = 4'he;
    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;
    typedef enum logic [2:0] {
        CTRL_IDLE, CTRL_INIT, CTRL_SBOX, CTRL_MAIN, CTRL_FINAL, CTRL_DONE
    } ctrl_state_t;
endpackage

// File: rtl/aes_decipher_ctrl.sv
// aes_decipher_ctrl: sequences round-key index, update type and S-box word for one block decipher.
module aes_decipher_ctrl
    import aes_decipher_ctrl_pkg::*;
#(
    parameter logic [3:0] AES128_ROUNDS = AES_128_NUM_ROUNDS,
    parameter logic [3:0] AES256_ROUNDS = AES_256_NUM_ROUNDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next,
    input  logic       keylen,
    output logic [3:0] round,
    output logic [2:0] update_type,
    output logic [1:0] sword_idx,
    output logic       ready
);
    ctrl_state_t state;
    logic [3:0]  round_ctr;
    logic [1:0]  sword_ctr;
    logic        keylen_r;
    assign round     = round_ctr;
    assign sword_idx = sword_ctr;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CTRL_IDLE;
            round_ctr   <= 4'd0;
            sword_ctr   <= 2'd0;
            keylen_r    <= AES_128_BIT_KEY;
            ready       <= 1'b1;
            update_type <= UPD_NO;
        end else begin
            case (state)
                CTRL_IDLE: if (next) begin
                    keylen_r    <= keylen;
                    round_ctr   <= (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
                    ready       <= 1'b0;
                    state       <= CTRL_INIT;
                    update_type <= UPD_INIT;
                end
                CTRL_INIT: begin
                    round_ctr   <= ((keylen_r == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS) - 4'd1;
                    sword_ctr   <= 2'd0;
                    state       <= CTRL_SBOX;
                    update_type <= UPD_SBOX;
                end
                CTRL_SBOX: begin
                    sword_ctr <= sword_ctr + 2'd1;
                    if (sword_ctr == 2'd3) begin
                        state       <= (round_ctr != 4'd0) ? CTRL_MAIN : CTRL_FINAL;
                        update_type <= (round_ctr != 4'd0) ? UPD_MAIN : UPD_FINAL;
                    end
                end
                CTRL_MAIN: begin
                    round_ctr   <= round_ctr - 4'd1;
                    sword_ctr   <= 2'd0;
                    state       <= CTRL_SBOX;
                    update_type <= UPD_SBOX;
                end
                CTRL_FINAL: begin
                    state       <= CTRL_DONE;
                    update_type <= UPD_NO;
                end
                CTRL_DONE: begin
                    state <= CTRL_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state       <= CTRL_IDLE;
                    ready       <= 1'b1;
                    update_type <= UPD_NO;
                end
            endcase
        end
    end
endmodule
